booth4_seq_accum: RTL and testbench

- Sequential radix-4 Booth multiplier core: accepts a signed WIDTH x WIDTH operand pair over a valid/ready handshake and holds the multiplicand.
- Issues one Booth digit triplet per cycle to the external Booth4 partial-product generator.
- Consumes the returned PP/E/S bits and accumulates them into a signed 2*WIDTH product.
- Sits directly downstream of Booth4 (consumes PP, E, S) and drives its A and B_pp inputs; the combinational loop-back completes within one cycle.

---
 rtl/booth4_seq_accum.sv | 94 +++++++++
 tb/tb_booth4_seq_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth4_seq_accum.sv
// Sequential radix-4 Booth multiplier core: issues one digit triplet per cycle to an
// external Booth4 partial-product generator and accumulates its PP/E/S into a signed product.
module booth4_seq_accum #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN_A,
    input  logic [WIDTH-1:0]     IN_B,
    output logic [WIDTH-1:0]     BOOTH_A,
    output logic [2:0]           BOOTH_B_PP,
    input  logic [WIDTH:0]       PP,
    input  logic                 E,
    input  logic                 S,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   OUT_P,
    output logic                 BUSY
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH:0]       r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_term;
    logic [2*WIDTH-1:0]   w_addend;
    logic                 w_last;
    logic                 w_accept;

    assign w_last   = (r_cnt == CW'(DIGITS - 1));
    assign w_accept = IN_VALID && (r_state == IDLE);

    // ~E is the partial-product sign; PP[WIDTH] is taken as delivered
    assign w_term   = {{(WIDTH-1){~E}}, PP};
    assign w_addend = (w_term + (2*WIDTH)'(S)) << {r_cnt, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (OUT_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_b holds {B, 1'b0} and shifts right two bits per digit, so bits [2:0] are the live triplet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= IN_A;
            r_b   <= {IN_B, 1'b0};
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_b   <= r_b >> 2;
            r_acc <= r_acc + w_addend;
        end
    end

    assign IN_READY   = (r_state == IDLE);
    assign BUSY       = (r_state == RUN);
    assign OUT_VALID  = (r_state == DONE);
    assign OUT_P      = r_acc;
    assign BOOTH_A    = r_a;
    assign BOOTH_B_PP = (r_state == RUN) ? r_b[2:0] : 3'b000;

endmodule

// File: tb/tb_booth4_seq_accum.sv
// Testbench for booth4_seq_accum: Booth4 generator model in the loop, table vectors,
// handshake corner cases and randomized operands against plain signed multiplication.
module tb_booth4_seq_accum;

    localparam int W      = 64;
    localparam int DIGITS = W / 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   IN_A;
    logic [W-1:0]   IN_B;
    logic [W-1:0]   BOOTH_A;
    logic [2:0]     BOOTH_B_PP;
    logic [W:0]     PP;
    logic           E;
    logic           S;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [2*W-1:0] OUT_P;
    logic           BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    booth4_seq_accum #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .BOOTH_A(BOOTH_A), .BOOTH_B_PP(BOOTH_B_PP),
        .PP(PP), .E(E), .S(S),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_P(OUT_P), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    // Booth4 partial-product generator model; garbage outside RUN
    int               m_d;
    logic signed [W:0] m_a;
    logic [W:0]       m_mag;
    logic [W+2:0]     junk;

    always @(negedge clk) junk <= (W+3)'({$urandom, $urandom, $urandom});

    always_comb begin
        m_d   = -2 * int'(BOOTH_B_PP[2]) + int'(BOOTH_B_PP[1]) + int'(BOOTH_B_PP[0]);
        m_a   = {BOOTH_A[W-1], BOOTH_A};
        m_mag = '0;
        if (m_d == 1 || m_d == -1)      m_mag = m_a;
        else if (m_d == 2 || m_d == -2) m_mag = m_a <<< 1;
        if (m_d < 0) begin
            PP = ~m_mag;
            S  = 1'b1;
        end else begin
            PP = m_mag;
            S  = 1'b0;
        end
        E = ~PP[W];
        if (!BUSY) {PP, E, S} = junk;
    end

    logic [2:0] trip_q[$];
    int         cyc = 0;
    int         acc_cyc[$];

    always @(negedge clk) if (BUSY) trip_q.push_back(BOOTH_B_PP);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (IN_VALID && IN_READY) acc_cyc.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, (2*W)'({IN_READY, OUT_VALID, BUSY, BOOTH_B_PP, BOOTH_A}),
            (2*W)'({1'b1, 1'b0, 1'b0, 3'b000, {W{1'b0}}}));
        chk({nm, "_p"}, OUT_P, '0);
    endtask

    function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    function automatic bit trips_ok(input logic [W-1:0] b);
        logic [W:0] bx;
        bx = {b, 1'b0};
        if (trip_q.size() != DIGITS) return 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (trip_q[i] !== bx[2*i+2 -: 3]) return 1'b0;
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where OUT_VALID is seen
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] p, output int lat);
        chk("idle_ready", (2*W)'(IN_READY), 1);
        trip_q.delete();
        IN_A     = a;
        IN_B     = b;
        IN_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        IN_VALID = 1'b0;
        chk("accept_state", (2*W)'({IN_READY, BUSY}), (2*W)'(2'b01));
        lat = 0;
        while (!OUT_VALID && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        p = OUT_P;
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t           vecs[8];
    logic [2*W-1:0] p;
    logic [2*W-1:0] held;
    logic [W-1:0]   ra, rb;
    int             lat;

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vecs[0] = '{64'd3, 64'd5, 128'd15};
        vecs[1] = '{'1, '1, 128'd1};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, '1, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'd0, 128'd0};
        vecs[5] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFF7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1};
        vecs[6] = '{64'd1, 64'h8000_0000_0000_0000, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};

        rst_n = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; IN_A = '0; IN_B = '0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, p, lat);
            chk($sformatf("vec%0d_p", i), p, vecs[i].p);
            chk($sformatf("vec%0d_lat", i), (2*W)'(lat), (2*W)'(DIGITS));
            chk($sformatf("vec%0d_trips", i), (2*W)'(trips_ok(vecs[i].b)), 1);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), (2*W)'({IN_READY, OUT_VALID}), (2*W)'(2'b10));
        end

        // Backpressure in DONE while IN_VALID toggles with a different operand
        OUT_READY = 1'b0;
        do_op(64'd123456789, 64'hFFFF_FFFF_FFFF_0000, p, lat);
        held = golden(64'd123456789, 64'hFFFF_FFFF_FFFF_0000);
        chk("bp_p", p, held);
        for (int k = 0; k < 10; k++) begin
            IN_VALID = k[0];
            IN_A     = 64'hDEAD_BEEF_0000_0000 + 64'(k);
            IN_B     = 64'd99;
            @(negedge clk);
            chk("bp_hold", {OUT_P}, held);
            chk("bp_flags", (2*W)'({OUT_VALID, IN_READY, BOOTH_A}), (2*W)'({2'b10, 64'd123456789}));
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge clk);
        chk("bp_release", (2*W)'({OUT_VALID, IN_READY, BOOTH_A}), (2*W)'({2'b01, 64'd123456789}));

        // Asynchronous reset at digit 17
        trip_q.delete();
        IN_A = 64'hCAFE_F00D_1234_5678; IN_B = 64'h8765_4321_0FED_CBA9; IN_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        IN_VALID = 1'b0;
        repeat (17) @(negedge clk);
        chk("midop_busy", (2*W)'(BUSY), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(64'd7, 64'hFFFF_FFFF_FFFF_FFF7, p, lat);
        chk("post_reset_p", p, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1);
        @(negedge clk);

        // Randomized back-to-back operations
        acc_cyc.delete();
        for (int i = 0; i < 800; i++) begin
            ra = pick();
            rb = pick();
            do_op(ra, rb, p, lat);
            chk("rand_p", p, golden(ra, rb));
            if (i % 50 == 0) chk("rand_trips", (2*W)'(trips_ok(rb)), 1);
            @(negedge clk);
        end
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("rand_spacing", (2*W)'(acc_cyc[i] - acc_cyc[i-1]), (2*W)'(DIGITS + 2));
        chk("rand_accepts", (2*W)'(acc_cyc.size()), 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
